stack_cpu_fsm: RTL and testbench

//  Parametrised multi-cycle stack-machine CPU for complex operands (real word, imag word).

---
 rtl/stack_cpu_pkg.sv | 77 +++++++
 rtl/stack_cpu_alu.sv | 69 ++++++
 rtl/stack_cpu_fsm.sv | 257 +++++++++++++++++++++++++
 tb/tb_stack_cpu_fsm.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_cpu_pkg.sv
// Shared definitions for the complex-operand stack CPU: opcodes, FSM state
// encoding, fault codes and per-opcode stack bookkeeping helpers.
package stack_cpu_pkg;

  // Opcodes: instruction word is {op[2:0], addr[AW-1:0]}
  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_POP  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MULT = 3'b100;
  localparam logic [2:0] OP_NOP5 = 3'b101;
  localparam logic [2:0] OP_NOP6 = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  // Fault codes reported on fault_code
  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_UNDER = 2'b01;
  localparam logic [1:0] FC_OVER  = 2'b10;

  // FSM state encoding
  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_FWAIT  = 4'd1,
    ST_DECODE = 4'd2,
    ST_RD     = 4'd3,
    ST_RWAIT  = 4'd4,
    ST_EXEC   = 4'd5,
    ST_WR     = 4'd6,
    ST_HALT   = 4'd7,
    ST_FAULT  = 4'd8
  } state_t;

  // Words removed from the stack by an opcode
  function automatic logic [2:0] pops_needed(input logic [2:0] op);
    logic [2:0] n;
    case (op)
      OP_POP:                  n = 3'd2;
      OP_ADD, OP_SUB, OP_MULT: n = 3'd4;
      default:                 n = 3'd0;
    endcase
    return n;
  endfunction

  // Words added to the stack by an opcode
  function automatic logic [2:0] pushes_made(input logic [2:0] op);
    logic [2:0] n;
    case (op)
      OP_PUSH, OP_ADD, OP_SUB: n = 3'd2;
      OP_MULT:                 n = 3'd4;
      default:                 n = 3'd0;
    endcase
    return n;
  endfunction

  // RAM reads needed to gather the operands of an opcode
  function automatic logic [2:0] reads_needed(input logic [2:0] op);
    logic [2:0] n;
    case (op)
      OP_PUSH, OP_POP:         n = 3'd2;
      OP_ADD, OP_SUB, OP_MULT: n = 3'd4;
      default:                 n = 3'd0;
    endcase
    return n;
  endfunction

  // RAM writes issued by an opcode (POP writes to memory, others push)
  function automatic logic [2:0] writes_needed(input logic [2:0] op);
    logic [2:0] n;
    case (op)
      OP_PUSH, OP_POP, OP_ADD, OP_SUB: n = 3'd2;
      OP_MULT:                         n = 3'd4;
      default:                         n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/stack_cpu_alu.sv
// Combinational complex arithmetic on the registered stack operands.
// Optional macro STACK_CPU_SAT_EN: ADD/SUB results saturate per component
// instead of wrapping; MULT always produces full 2N-bit signed products.
module stack_cpu_alu
  import stack_cpu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]   i_re1,
  input  logic [N-1:0]   i_im1,
  input  logic [N-1:0]   i_re2,
  input  logic [N-1:0]   i_im2,
  input  logic           i_sub,
  output logic [N-1:0]   o_re_as,
  output logic [N-1:0]   o_im_as,
  output logic [2*N-1:0] o_re_mul,
  output logic [2*N-1:0] o_im_mul
);

  // a +/- b with one guard bit; clamps when the guard disagrees with the sign
  function automatic logic [N-1:0] add_sub(input logic [N-1:0] a,
                                           input logic [N-1:0] b,
                                           input logic         sub);
    logic [N:0]   ea;
    logic [N:0]   eb;
    logic [N:0]   s;
    logic [N-1:0] r;
    ea = {a[N-1], a};
    eb = {b[N-1], b};
    if (sub) begin
      s = ea - eb;
    end else begin
      s = ea + eb;
    end
    r = s[N-1:0];
`ifdef STACK_CPU_SAT_EN
    if (s[N] != s[N-1]) begin
      if (s[N]) begin
        r = {1'b1, {(N-1){1'b0}}};
      end else begin
        r = {1'b0, {(N-1){1'b1}}};
      end
    end else begin
      r = s[N-1:0];
    end
`endif
    return r;
  endfunction

  logic [2*N-1:0] w_re1_x;
  logic [2*N-1:0] w_im1_x;
  logic [2*N-1:0] w_re2_x;
  logic [2*N-1:0] w_im2_x;

  // Sign-extend operands so 2N-bit products keep correct two's complement bits
  assign w_re1_x = {{N{i_re1[N-1]}}, i_re1};
  assign w_im1_x = {{N{i_im1[N-1]}}, i_im1};
  assign w_re2_x = {{N{i_re2[N-1]}}, i_re2};
  assign w_im2_x = {{N{i_im2[N-1]}}, i_im2};

  // Result = op2 (+|-|*) op1, computed component-wise
  always_comb begin
    o_re_as  = add_sub(i_re2, i_re1, i_sub);
    o_im_as  = add_sub(i_im2, i_im1, i_sub);
    o_re_mul = (w_re2_x * w_re1_x) - (w_im2_x * w_im1_x);
    o_im_mul = (w_re2_x * w_im1_x) + (w_im2_x * w_re1_x);
  end

endmodule

// File: rtl/stack_cpu_fsm.sv
// Multi-cycle complex-operand stack CPU. Program, data and a downward-growing
// stack share one registered-read RAM. ram_raddr is loaded one state ahead so
// that it is stable during FETCH/RD and the data is captured in FWAIT/RWAIT.
// Optional macro STACK_CPU_SAT_EN enables saturating ADD/SUB (see the ALU).
module stack_cpu_fsm
  import stack_cpu_pkg::*;
#(
  parameter int  N           = 8,
  parameter int  STACK_DEPTH = 16,
  localparam int AW          = N - 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [N-1:0]  ram_rdata,
  output logic [AW-1:0] ram_raddr,
  output logic          ram_w,
  output logic [AW-1:0] ram_waddr,
  output logic [N-1:0]  ram_wdata,
  output logic          halted,
  output logic          fault,
  output logic [1:0]    fault_code
);

  localparam int CW = AW + 1;
  localparam int CX = CW + 1;

  state_t        r_state;
  logic [AW-1:0] r_pc;
  logic [N-1:0]  r_ir;
  logic [AW-1:0] r_sp;
  logic [CW-1:0] r_count;
  logic [N-1:0]  r_opd [4];
  logic [N-1:0]  r_res [4];
  logic [1:0]    r_ridx;
  logic [1:0]    r_widx;
  logic [2:0]    r_nrd;
  logic [2:0]    r_nwr;
  logic [AW-1:0] r_rbase;
  logic [AW-1:0] r_wbase;
  logic [AW-1:0] r_raddr;
  logic          r_ram_w;
  logic [AW-1:0] r_waddr;
  logic [N-1:0]  r_wdata;
  logic          r_halted;
  logic          r_fault;
  logic [1:0]    r_fault_code;

  logic [2:0]    w_op;
  logic [AW-1:0] w_addr;
  logic [2:0]    w_pops;
  logic [2:0]    w_pushes;
  logic [2:0]    w_nrd;
  logic [2:0]    w_nwr;
  logic [CX-1:0] w_cnt_after;
  logic          w_under;
  logic          w_over;
  logic          w_is_nop;
  logic [AW-1:0] w_sp_next;
  logic [AW-1:0] w_rbase;
  logic [AW-1:0] w_wbase;
  logic [N-1:0]  w_re_as;
  logic [N-1:0]  w_im_as;
  logic [2*N-1:0] w_re_mul;
  logic [2*N-1:0] w_im_mul;
  logic [N-1:0]  w_word [4];

  assign w_op   = r_ir[N-1 -: 3];
  assign w_addr = r_ir[AW-1:0];

  // Stack operand layout after the reads: [0]=im1 (top), [1]=re1, [2]=im2, [3]=re2
  stack_cpu_alu #(.N(N)) u_alu (
    .i_re1    (r_opd[1]),
    .i_im1    (r_opd[0]),
    .i_re2    (r_opd[3]),
    .i_im2    (r_opd[2]),
    .i_sub    (w_op == OP_SUB),
    .o_re_as  (w_re_as),
    .o_im_as  (w_im_as),
    .o_re_mul (w_re_mul),
    .o_im_mul (w_im_mul)
  );

  // Decode: stack bookkeeping, fault detection and read/write base addresses
  always_comb begin
    w_pops      = pops_needed(w_op);
    w_pushes    = pushes_made(w_op);
    w_nrd       = reads_needed(w_op);
    w_nwr       = writes_needed(w_op);
    w_cnt_after = CX'(r_count) - CX'(w_pops) + CX'(w_pushes);
    w_under     = (CX'(r_count) < CX'(w_pops));
    w_over      = (w_cnt_after > CX'(STACK_DEPTH));
    w_is_nop    = (w_op == OP_NOP5) || (w_op == OP_NOP6);
    w_sp_next   = r_sp + AW'(w_pops) - AW'(w_pushes);
    w_rbase     = r_sp + AW'(1'b1);
    w_wbase     = r_sp + AW'(3'd4);
    case (w_op)
      OP_PUSH: begin
        w_rbase = w_addr;
        w_wbase = r_sp;
      end
      OP_POP: begin
        w_rbase = r_sp + AW'(1'b1);
        w_wbase = w_addr + AW'(1'b1);
      end
      default: begin
        w_rbase = r_sp + AW'(1'b1);
        w_wbase = r_sp + AW'(3'd4);
      end
    endcase
  end

  // Write-word ordering; writes go to descending addresses from r_wbase
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_word[k] = {N{1'b0}};
    end
    case (w_op)
      OP_PUSH, OP_POP: begin
        w_word[0] = r_opd[0];
        w_word[1] = r_opd[1];
      end
      OP_ADD, OP_SUB: begin
        w_word[0] = w_re_as;
        w_word[1] = w_im_as;
      end
      OP_MULT: begin
        w_word[0] = w_re_mul[2*N-1:N];
        w_word[1] = w_re_mul[N-1:0];
        w_word[2] = w_im_mul[2*N-1:N];
        w_word[3] = w_im_mul[N-1:0];
      end
      default: begin
        w_word[0] = {N{1'b0}};
      end
    endcase
  end

  // Main FSM: sequencing, architectural state and registered RAM/status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_FETCH;
      r_pc         <= {AW{1'b0}};
      r_ir         <= {N{1'b0}};
      r_sp         <= {AW{1'b1}};
      r_count      <= {CW{1'b0}};
      for (int k = 0; k < 4; k++) begin
        r_opd[k] <= {N{1'b0}};
        r_res[k] <= {N{1'b0}};
      end
      r_ridx       <= 2'd0;
      r_widx       <= 2'd0;
      r_nrd        <= 3'd0;
      r_nwr        <= 3'd0;
      r_rbase      <= {AW{1'b0}};
      r_wbase      <= {AW{1'b0}};
      r_raddr      <= {AW{1'b0}};
      r_ram_w      <= 1'b0;
      r_waddr      <= {AW{1'b0}};
      r_wdata      <= {N{1'b0}};
      r_halted     <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_code <= FC_NONE;
    end else if (en) begin
      case (r_state)
        ST_FETCH: begin
          r_state <= ST_FWAIT;
        end
        ST_FWAIT: begin
          r_ir    <= ram_rdata;
          r_state <= ST_DECODE;
        end
        ST_DECODE: begin
          r_pc <= r_pc + AW'(1'b1);
          if (w_op == OP_HALT) begin
            r_halted <= 1'b1;
            r_state  <= ST_HALT;
          end else if (w_is_nop) begin
            r_raddr <= r_pc + AW'(1'b1);
            r_state <= ST_FETCH;
          end else if (w_under) begin
            r_fault      <= 1'b1;
            r_fault_code <= FC_UNDER;
            r_state      <= ST_FAULT;
          end else if (w_over) begin
            r_fault      <= 1'b1;
            r_fault_code <= FC_OVER;
            r_state      <= ST_FAULT;
          end else begin
            r_rbase <= w_rbase;
            r_wbase <= w_wbase;
            r_nrd   <= w_nrd;
            r_nwr   <= w_nwr;
            r_sp    <= w_sp_next;
            r_count <= w_cnt_after[CW-1:0];
            r_ridx  <= 2'd0;
            r_raddr <= w_rbase;
            r_state <= ST_RD;
          end
        end
        ST_RD: begin
          r_state <= ST_RWAIT;
        end
        ST_RWAIT: begin
          r_opd[r_ridx] <= ram_rdata;
          if (({1'b0, r_ridx} + 3'd1) < r_nrd) begin
            r_ridx  <= r_ridx + 2'd1;
            r_raddr <= r_rbase + AW'(r_ridx) + AW'(1'b1);
            r_state <= ST_RD;
          end else begin
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          for (int k = 0; k < 4; k++) begin
            r_res[k] <= w_word[k];
          end
          r_widx  <= 2'd0;
          r_ram_w <= 1'b1;
          r_waddr <= r_wbase;
          r_wdata <= w_word[0];
          r_state <= ST_WR;
        end
        ST_WR: begin
          if (({1'b0, r_widx} + 3'd1) < r_nwr) begin
            r_widx  <= r_widx + 2'd1;
            r_waddr <= r_wbase - AW'(r_widx) - AW'(1'b1);
            r_wdata <= r_res[r_widx + 2'd1];
          end else begin
            r_ram_w <= 1'b0;
            r_raddr <= r_pc;
            r_state <= ST_FETCH;
          end
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        ST_FAULT: begin
          r_state <= ST_FAULT;
        end
        default: begin
          r_ram_w <= 1'b0;
          r_state <= ST_FAULT;
        end
      endcase
    end
  end

  assign ram_raddr  = r_raddr;
  assign ram_w      = r_ram_w & en;
  assign ram_waddr  = r_waddr;
  assign ram_wdata  = r_wdata;
  assign halted     = r_halted;
  assign fault      = r_fault;
  assign fault_code = r_fault_code;

endmodule

// File: tb/tb_stack_cpu_fsm.sv
// Directed self-checking bench for stack_cpu_fsm (N=8) with a registered RAM model.
module tb_stack_cpu_fsm;
  import stack_cpu_pkg::*;

  localparam int N  = 8;
  localparam int AW = 5;

  logic          clk;
  logic          reset;
  logic          en;
  logic [N-1:0]  ram_rdata;
  logic [AW-1:0] ram_raddr;
  logic          ram_w;
  logic [AW-1:0] ram_waddr;
  logic [N-1:0]  ram_wdata;
  logic          halted;
  logic          fault;
  logic [1:0]    fault_code;

  logic [N-1:0]  mem [32];
  logic          tb_we;
  logic [AW-1:0] tb_addr;
  logic [N-1:0]  tb_data;
  int            n_wr = 0;
  int            n_checks;
  int            n_fail;
  int            w0;
  bit            found;

  stack_cpu_fsm #(.N(N), .STACK_DEPTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .ram_rdata  (ram_rdata),
    .ram_raddr  (ram_raddr),
    .ram_w      (ram_w),
    .ram_waddr  (ram_waddr),
    .ram_wdata  (ram_wdata),
    .halted     (halted),
    .fault      (fault),
    .fault_code (fault_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registered-read RAM; bench loader port has priority over CPU writes
  always @(posedge clk) begin
    if (tb_we) begin
      mem[tb_addr] <= tb_data;
    end else if (ram_w) begin
      mem[ram_waddr] <= ram_wdata;
      n_wr <= n_wr + 1;
    end
    ram_rdata <= mem[ram_raddr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int addr, input logic [7:0] data);
    tb_we   = 1'b1;
    tb_addr = AW'(addr);
    tb_data = data;
    @(posedge clk);
    #1;
    tb_we   = 1'b0;
  endtask

  // Hold the CPU in reset, clear RAM and place four data words at 20..23
  task automatic prep(input logic [7:0] d0, input logic [7:0] d1,
                      input logic [7:0] d2, input logic [7:0] d3);
    reset = 1'b0;
    en    = 1'b1;
    for (int a = 0; a < 32; a++) load(a, 8'h00);
    load(20, d0);
    load(21, d1);
    load(22, d2);
    load(23, d3);
  endtask

  task automatic run_until_stop(input string tag, input int budget);
    bit done;
    done  = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk);
      #1;
      if (halted || fault) done = 1'b1;
    end
    check({tag, "_stop"}, 32'(done), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_raddr"}, 32'(ram_raddr), 32'd0);
    check({tag, "_ram_w"}, 32'(ram_w), 32'd0);
    check({tag, "_waddr"}, 32'(ram_waddr), 32'd0);
    check({tag, "_wdata"}, 32'(ram_wdata), 32'd0);
    check({tag, "_halted"}, 32'(halted), 32'd0);
    check({tag, "_fault"}, 32'(fault), 32'd0);
    check({tag, "_fcode"}, 32'(fault_code), 32'd0);
    check({tag, "_pc"}, 32'(dut.r_pc), 32'd0);
    check({tag, "_sp"}, 32'(dut.r_sp), 32'd31);
    check({tag, "_count"}, 32'(dut.r_count), 32'd0);
    check({tag, "_state"}, 32'(dut.r_state), 32'(ST_FETCH));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    tb_we    = 1'b0;
    tb_addr  = '0;
    tb_data  = '0;
    reset    = 1'b0;
    en       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst");

    // PUSH 20, PUSH 22, ADD, POP 24, HALT: (3+4i)+(1+2i) = 4+6i
    prep(8'd3, 8'd4, 8'd1, 8'd2);
    load(0, 8'h14); load(1, 8'h16); load(2, 8'h40); load(3, 8'h38); load(4, 8'hE0);
    w0 = n_wr;
    run_until_stop("add", 400);
    check("add_mem24", 32'(mem[24]), 32'd4);
    check("add_mem25", 32'(mem[25]), 32'd6);
    check("add_halted", 32'(halted), 32'd1);
    check("add_fault", 32'(fault), 32'd0);
    check("add_sp", 32'(dut.r_sp), 32'd31);
    check("add_count", 32'(dut.r_count), 32'd0);
    check("add_pc", 32'(dut.r_pc), 32'd5);
    check("add_writes", 32'(n_wr - w0), 32'd8);

    // Same program with SUB: (3+4i)-(1+2i) = 2+2i
    prep(8'd3, 8'd4, 8'd1, 8'd2);
    load(0, 8'h14); load(1, 8'h16); load(2, 8'h60); load(3, 8'h38); load(4, 8'hE0);
    run_until_stop("sub", 400);
    check("sub_mem24", 32'(mem[24]), 32'd2);
    check("sub_mem25", 32'(mem[25]), 32'd2);

    // MULT: (3+4i)(1+2i) = -5+10i as 16-bit halves
    prep(8'd3, 8'd4, 8'd1, 8'd2);
    load(0, 8'h14); load(1, 8'h16); load(2, 8'h80); load(3, 8'h38); load(4, 8'h3A); load(5, 8'hE0);
    w0 = n_wr;
    run_until_stop("mul", 400);
    check("mul_mem24", 32'(mem[24]), 32'h00);
    check("mul_mem25", 32'(mem[25]), 32'h0A);
    check("mul_mem26", 32'(mem[26]), 32'hFF);
    check("mul_mem27", 32'(mem[27]), 32'hFB);
    check("mul_writes", 32'(n_wr - w0), 32'd12);
    check("mul_sp", 32'(dut.r_sp), 32'd31);

    // 100+100 overflows the real part: wrap or saturate
    prep(8'd100, 8'd0, 8'd100, 8'd0);
    load(0, 8'h14); load(1, 8'h16); load(2, 8'h40); load(3, 8'h38); load(4, 8'hE0);
    run_until_stop("sat", 400);
`ifdef STACK_CPU_SAT_EN
    check("sat_mem24", 32'(mem[24]), 32'h7F);
`else
    check("sat_mem24", 32'(mem[24]), 32'hC8);
`endif
    check("sat_mem25", 32'(mem[25]), 32'h00);

    // ADD on an empty stack: underflow, no writes, stuck in FAULT
    prep(8'd3, 8'd4, 8'd1, 8'd2);
    load(0, 8'h40); load(1, 8'hE0);
    w0 = n_wr;
    run_until_stop("unf", 100);
    repeat (10) @(posedge clk);
    #1;
    check("unf_fault", 32'(fault), 32'd1);
    check("unf_fcode", 32'(fault_code), 32'(FC_UNDER));
    check("unf_halted", 32'(halted), 32'd0);
    check("unf_writes", 32'(n_wr - w0), 32'd0);
    check("unf_pc", 32'(dut.r_pc), 32'd1);
    check("unf_state", 32'(dut.r_state), 32'(ST_FAULT));

    // Nine PUSHes: the ninth would take the stack to 18 > 16 words
    prep(8'd3, 8'd4, 8'd1, 8'd2);
    for (int a = 0; a < 9; a++) load(a, 8'h00);
    load(9, 8'hE0);
    w0 = n_wr;
    run_until_stop("ovf", 1000);
    check("ovf_fault", 32'(fault), 32'd1);
    check("ovf_fcode", 32'(fault_code), 32'(FC_OVER));
    check("ovf_writes", 32'(n_wr - w0), 32'd16);
    check("ovf_count", 32'(dut.r_count), 32'd16);
    check("ovf_sp", 32'(dut.r_sp), 32'd15);
    check("ovf_pc", 32'(dut.r_pc), 32'd9);

    // en freeze during the first PUSH read wait and during a write
    prep(8'd3, 8'd4, 8'd1, 8'd2);
    load(0, 8'h14); load(1, 8'h16); load(2, 8'h80); load(3, 8'h38); load(4, 8'h3A); load(5, 8'hE0);
    w0    = n_wr;
    reset = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk);
      #1;
      if (dut.r_state == ST_RWAIT) found = 1'b1;
    end
    check("frz_rwait_seen", 32'(found), 32'd1);
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("frz_rwait_hold", 32'(dut.r_state), 32'(ST_RWAIT));
    check("frz_raddr_hold", 32'(ram_raddr), 32'd20);
    en    = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk);
      #1;
      if (dut.r_state == ST_WR) found = 1'b1;
    end
    check("frz_wr_seen", 32'(found), 32'd1);
    check("frz_wr_active", 32'(ram_w), 32'd1);
    en = 1'b0;
    #1;
    check("frz_wr_gated", 32'(ram_w), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("frz_wr_hold", 32'(dut.r_state), 32'(ST_WR));
    en = 1'b1;
    run_until_stop("frz", 400);
    check("frz_mem24", 32'(mem[24]), 32'h00);
    check("frz_mem25", 32'(mem[25]), 32'h0A);
    check("frz_mem26", 32'(mem[26]), 32'hFF);
    check("frz_mem27", 32'(mem[27]), 32'hFB);
    check("frz_writes", 32'(n_wr - w0), 32'd12);

    // Rerun and assert reset while MULT is writing its result
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk);
      #1;
      if (dut.r_pc == 5'd3 && dut.r_state == ST_WR) found = 1'b1;
    end
    check("mrst_seen", 32'(found), 32'd1);
    check("mrst_ram_w_pre", 32'(ram_w), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_state("mrst");
    repeat (2) @(posedge clk);
    #1;
    check("mrst_hold_ram_w", 32'(ram_w), 32'd0);
    check("mrst_hold_state", 32'(dut.r_state), 32'(ST_FETCH));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
